load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width on the pipeline and memory sides.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 memRead  input  1  pipeline load request.
REQ-005 memWrite  input  1  pipeline store request.
REQ-006 func3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 aluOut  input  ADDR_W  byte address.
REQ-008 data2  input  32  store data, right-aligned.
REQ-009 stall  output  1  freeze the pipeline while the operation is incomplete.
REQ-010 memData  output  32  extended load result; valid only while loadValid=1.
REQ-011 loadValid  output  1  one-cycle completion pulse for loads.
REQ-012 accessErr  output  1  one-cycle pulse for an illegal request.
REQ-013 memReq, memWe  output  1 each  memory request strobe and write flag.
REQ-014 memAddr  output  ADDR_W  word-aligned address; bits [1:0] always 0.
REQ-015 memWdata  output  32  lane-positioned write data.
REQ-016 memBe  output  4  byte enables; bit i selects byte lane i.
REQ-017 memGnt  input  1  memory accepts the current request.
REQ-018 memRvalid, memRdata  input  1, 32  read response.

Function
REQ-019 FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
REQ-020 A request starts in IDLE when memRead^memWrite=1; at that edge capture func3, aluOut and data2, then go to REQ1.
REQ-021 Illegal request: memRead&memWrite=1, or a load with func3 in {011,110,111}, or a store with func3 not in {000,001,010}. Action: IDLE->DONE, no memory access, accessErr=1 in DONE, memData=0.
REQ-022 stall=1 combinationally in IDLE with a request pending, and in REQ1, WAIT1, REQ2 and WAIT2; stall=0 in DONE and in idle IDLE.
REQ-023 Let off = addr[1:0] and size = 1/2/4 bytes. The access splits when off+size>4; otherwise it uses one beat.
REQ-024 Beat 1: memAddr={addr[ADDR_W-1:2],2'b00}; memBe=(mask(size)<<off)[3:0]; memWdata=data2<<(8*off).
REQ-025 Beat 2: memAddr=beat-1 address+4, wrapping modulo 2^ADDR_W; memBe=mask(size)>>(4-off); memWdata=data2>>(8*(4-off)).
REQ-026 In REQ1/REQ2, memReq=1 and memAddr, memWe, memBe and memWdata are held stable until memGnt=1 is sampled.
REQ-027 Store transitions on grant: REQ1->REQ2 if split, else REQ1->DONE; REQ2->DONE.
REQ-028 Load transitions on grant: REQ1->WAIT1; REQ2->WAIT2. memRvalid is ignored in REQ states and in IDLE/DONE.
REQ-029 WAIT1 on memRvalid: store memRdata>>(8*off) into low bytes; go to REQ2 if split, else DONE.
REQ-030 WAIT2 on memRvalid: merge memRdata<<(8*(4-off)) into the upper bytes; go to DONE.
REQ-031 DONE lasts one cycle and always returns to IDLE. A new request is accepted in the IDLE cycle that follows; back-to-back requests therefore have at least a one-cycle gap.
REQ-032 In DONE for a load: loadValid=1 and memData = the assembled bytes, sign-extended (LB, LH) or zero-extended (LBU, LHU); LW is passed unchanged.
REQ-033 Outside DONE: memData=0, loadValid=0, accessErr=0. memReq=0 outside REQ1/REQ2.
REQ-034 Minimum latency (entry to DONE): aligned store 2 cycles; aligned load 3 cycles. Each wait cycle on memGnt or memRvalid adds one cycle.

Reset
REQ-035 rst=1 forces IDLE asynchronously, clears all captured registers, and drives every output to 0.
REQ-036 Reset mid-operation aborts the access. No memReq is issued after reset; a memRvalid arriving after reset is ignored.

Verification
REQ-037 SW addr 0x100, data 0xDEADBEEF, memGnt=1 immediately -> one beat, memAddr=0x100, memBe=1111, memWdata=0xDEADBEEF; stall high 2 cycles.
REQ-038 LH addr 0x103, memory words 0x100=0x80112233 and 0x104=0x44556677 -> two beats (memBe 1000, then 0001); memData=0x00007780, loadValid for 1 cycle.
REQ-039 LBU addr 0x101, memRdata=0x0000F000 -> memBe=0010, memData=0x000000F0; LB at the same address -> memData=0xFFFFFFF0.
REQ-040 SW addr 0xFFFFFFFE, data 0x11223344 -> beat 1 at 0xFFFFFFFC with memBe=1100 and memWdata=0x33440000; beat 2 at 0x00000000 with memBe=0011 and memWdata=0x00001122.
REQ-041 LW with memGnt held low for 3 cycles -> request fields stable throughout, stall high; assert rst in WAIT1 -> memReq=0, stall=0, IDLE; a late memRvalid has no effect.
REQ-042 memRead=memWrite=1 -> no memReq; accessErr=1 for one cycle; memData=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Pipeline-side and memory-side signals of the load/store unit.
// The slave modport is the unit itself; master is its environment.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              memRead;
  logic              memWrite;
  logic [2:0]        func3;
  logic [ADDR_W-1:0] aluOut;
  logic [31:0]       data2;
  logic              stall;
  logic [31:0]       memData;
  logic              loadValid;
  logic              accessErr;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [3:0]        memBe;
  logic              memGnt;
  logic              memRvalid;
  logic [31:0]       memRdata;

  modport slave (
    input  memRead, memWrite, func3, aluOut, data2, memGnt, memRvalid, memRdata,
    output stall, memData, loadValid, accessErr, memReq, memWe, memAddr, memWdata, memBe
  );

  modport master (
    output memRead, memWrite, func3, aluOut, data2, memGnt, memRvalid, memRdata,
    input  stall, memData, loadValid, accessErr, memReq, memWe, memAddr, memWdata, memBe
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word accesses onto 32-bit word memory, splitting misaligned ones in two beats.
// Latency: aligned store 2 cycles, aligned load 3; a split adds a beat; +1 per cycle waiting on memGnt/memRvalid.
// Backpressure: stall freezes the pipeline; each beat is held stable on the memory side until memGnt.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave lsu_bus
);
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_func3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [31:0]       r_rdata;
  logic              r_load;
  logic              r_err;

  logic              w_req;
  logic              w_legal;
  logic [1:0]        w_off;
  logic [2:0]        w_size;
  logic [3:0]        w_mask;
  logic              w_split;
  logic [2:0]        w_sh_be;
  logic [5:0]        w_sh_lo;
  logic [5:0]        w_sh_hi;
  logic [ADDR_W-1:0] w_addr1;
  logic [ADDR_W-1:0] w_addr2;
  logic [3:0]        w_be1;
  logic [3:0]        w_be2;
  logic [31:0]       w_wdata1;
  logic [31:0]       w_wdata2;
  logic [31:0]       w_ext;

  logic              w_stall;
  logic              w_mem_req;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [3:0]        w_mem_be;
  logic [31:0]       w_mem_wdata;
  logic              w_load_valid;
  logic              w_access_err;
  logic [31:0]       w_mem_data;

  assign w_req = lsu_bus.memRead | lsu_bus.memWrite;

  // Only exactly one of read/write may be set; stores have no unsigned forms.
  always_comb begin
    w_legal = 1'b0;
    if (lsu_bus.memRead ^ lsu_bus.memWrite) begin
      case (lsu_bus.func3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b100, 3'b101:         w_legal = lsu_bus.memRead;
        default:                w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_size = 3'd4;
    w_mask = 4'b1111;
    case (r_func3[1:0])
      2'b00: begin w_size = 3'd1; w_mask = 4'b0001; end
      2'b01: begin w_size = 3'd2; w_mask = 4'b0011; end
      default: ;
    endcase
  end

  assign w_off    = r_addr[1:0];
  assign w_split  = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_sh_be  = 3'd4 - {1'b0, w_off};
  assign w_sh_lo  = {1'b0, w_off, 3'b000};
  assign w_sh_hi  = 6'd32 - w_sh_lo;
  assign w_addr1  = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_addr2  = w_addr1 + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign w_be1    = w_mask << w_off;
  assign w_be2    = w_mask >> w_sh_be;
  assign w_wdata1 = r_data << w_sh_lo;
  assign w_wdata2 = r_data >> w_sh_hi;

  always_comb begin
    case (r_func3)
      3'b000:  w_ext = {{24{r_rdata[7]}}, r_rdata[7:0]};
      3'b001:  w_ext = {{16{r_rdata[15]}}, r_rdata[15:0]};
      3'b100:  w_ext = {24'd0, r_rdata[7:0]};
      3'b101:  w_ext = {16'd0, r_rdata[15:0]};
      default: w_ext = r_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_func3 <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_req) begin
          r_func3 <= lsu_bus.func3;
          r_addr  <= lsu_bus.aluOut;
          r_data  <= lsu_bus.data2;
          r_load  <= lsu_bus.memRead;
          r_err   <= ~w_legal;
          r_rdata <= '0;
        end
        WAIT1: if (lsu_bus.memRvalid) r_rdata <= lsu_bus.memRdata >> w_sh_lo;
        // Second beat supplies the bytes above the first word's tail.
        WAIT2: if (lsu_bus.memRvalid) r_rdata <= r_rdata | (lsu_bus.memRdata << w_sh_hi);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    w_stall      = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_be     = '0;
    w_mem_wdata  = '0;
    w_load_valid = 1'b0;
    w_access_err = 1'b0;
    w_mem_data   = '0;
    case (r_state)
      IDLE: begin
        w_stall = w_req & ~rst;
        if (w_req) w_next = w_legal ? REQ1 : DONE;
      end
      REQ1: begin
        w_stall     = 1'b1;
        w_mem_req   = 1'b1;
        w_mem_we    = ~r_load;
        w_mem_addr  = w_addr1;
        w_mem_be    = w_be1;
        w_mem_wdata = w_wdata1;
        if (lsu_bus.memGnt) w_next = r_load ? WAIT1 : (w_split ? REQ2 : DONE);
      end
      WAIT1: begin
        w_stall = 1'b1;
        if (lsu_bus.memRvalid) w_next = w_split ? REQ2 : DONE;
      end
      REQ2: begin
        w_stall     = 1'b1;
        w_mem_req   = 1'b1;
        w_mem_we    = ~r_load;
        w_mem_addr  = w_addr2;
        w_mem_be    = w_be2;
        w_mem_wdata = w_wdata2;
        if (lsu_bus.memGnt) w_next = r_load ? WAIT2 : DONE;
      end
      WAIT2: begin
        w_stall = 1'b1;
        if (lsu_bus.memRvalid) w_next = DONE;
      end
      DONE: begin
        w_load_valid = r_load & ~r_err;
        w_access_err = r_err;
        w_mem_data   = (r_load & ~r_err) ? w_ext : 32'd0;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign lsu_bus.stall     = w_stall;
  assign lsu_bus.memReq    = w_mem_req;
  assign lsu_bus.memWe     = w_mem_we;
  assign lsu_bus.memAddr   = w_mem_addr;
  assign lsu_bus.memBe     = w_mem_be;
  assign lsu_bus.memWdata  = w_mem_wdata;
  assign lsu_bus.loadValid = w_load_valid;
  assign lsu_bus.accessErr = w_access_err;
  assign lsu_bus.memData   = w_mem_data;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: scoreboarded memory beats and results against a small word memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();
  load_store_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .lsu_bus(bus.slave));

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic        lv;
    logic        err;
    logic [31:0] data;
  } res_t;

  beat_t beat_q[$];
  res_t  res_q[$];
  bit [31:0] mem [bit [31:0]];
  int checks = 0;
  int errors = 0;

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    beat_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic push_res(input logic lv, input logic err, input logic [31:0] d);
    res_t r;
    r.lv = lv; r.err = err; r.data = d;
    res_q.push_back(r);
  endtask

  // Drives one pipeline request and plays the memory until the unit leaves its stall.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int gnt_dly, input int rv_dly, input int exp_stall, input string name);
    beat_t cur, exp_b;
    res_t  got, er;
    bit in_beat = 0, pending = 0, done = 0;
    int gcnt = 0, rcnt = 0, nstall = 0;
    logic [31:0] rsp_addr = '0;
    exp_b = '0;
    @(negedge clk);
    checks++;
    if (bus.loadValid !== 1'b0 || bus.accessErr !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_pulse: loadValid=%b accessErr=%b, required 0 0", name, bus.loadValid, bus.accessErr);
    end
    bus.memRead = rd; bus.memWrite = wr; bus.func3 = f3; bus.aluOut = addr; bus.data2 = data;
    #1;
    if (bus.stall === 1'b1) nstall++;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      bus.memRead = 0; bus.memWrite = 0; bus.memGnt = 0; bus.memRvalid = 0; bus.memRdata = '0;
      #1;
      if (bus.stall !== 1'b1) begin
        done = 1;
        got.lv = bus.loadValid; got.err = bus.accessErr; got.data = bus.memData;
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_result: no expected result queued", name);
        end else begin
          er = res_q.pop_front();
          checks++;
          if (got !== er || bus.memReq !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: lv=%b err=%b data=%h req=%b, required lv=%b err=%b data=%h req=0",
                     name, got.lv, got.err, got.data, bus.memReq, er.lv, er.err, er.data);
          end
        end
      end else begin
        nstall++;
        if (bus.memReq === 1'b1) begin
          cur.addr = bus.memAddr; cur.be = bus.memBe; cur.we = bus.memWe; cur.wdata = bus.memWdata;
          checks++;
          if (!in_beat) begin
            if (beat_q.size() == 0) begin
              errors++;
              $display("FAIL %s_beat: unexpected beat addr=%h be=%b", name, cur.addr, cur.be);
              exp_b = cur;
            end else begin
              exp_b = beat_q.pop_front();
              if (cur !== exp_b) begin
                errors++;
                $display("FAIL %s_beat: addr=%h be=%b we=%b wdata=%h, required addr=%h be=%b we=%b wdata=%h",
                         name, cur.addr, cur.be, cur.we, cur.wdata, exp_b.addr, exp_b.be, exp_b.we, exp_b.wdata);
              end
            end
            in_beat = 1; gcnt = 0;
          end else if (cur !== exp_b) begin
            errors++;
            $display("FAIL %s_hold: addr=%h be=%b we=%b wdata=%h, required addr=%h be=%b we=%b wdata=%h",
                     name, cur.addr, cur.be, cur.we, cur.wdata, exp_b.addr, exp_b.be, exp_b.we, exp_b.wdata);
          end
          if (gcnt == gnt_dly) begin
            bus.memGnt = 1; in_beat = 0;
            if (bus.memWe === 1'b0) begin pending = 1; rsp_addr = bus.memAddr; rcnt = 0; end
          end else gcnt++;
        end else if (pending) begin
          if (rcnt == rv_dly) begin
            bus.memRvalid = 1;
            bus.memRdata = mem.exists(rsp_addr) ? mem[rsp_addr] : 32'h0;
            pending = 0;
          end else rcnt++;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: stall still high after 40 cycles, required completion", name);
    end
    checks++;
    if (nstall != exp_stall) begin
      errors++;
      $display("FAIL %s_stall_cycles: %0d, required %0d", name, nstall, exp_stall);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    bus.memRead = 1; bus.memWrite = 0; bus.func3 = 3'b010; bus.aluOut = 32'h100; bus.data2 = '0;
    bus.memGnt = 0; bus.memRvalid = 0; bus.memRdata = '0;
    #12;
    checks++;
    if (bus.stall !== 1'b0 || bus.memReq !== 1'b0 || bus.memWe !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall=%b memReq=%b memWe=%b, required 0 0 0", bus.stall, bus.memReq, bus.memWe);
    end
    checks++;
    if (bus.memAddr !== 32'h0 || bus.memBe !== 4'h0 || bus.memWdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h be=%b wdata=%h, required 0 0 0", bus.memAddr, bus.memBe, bus.memWdata);
    end
    checks++;
    if (bus.loadValid !== 1'b0 || bus.accessErr !== 1'b0 || bus.memData !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: lv=%b err=%b data=%h, required 0 0 0", bus.loadValid, bus.accessErr, bus.memData);
    end
    bus.memRead = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_aligned_store;
    push_beat(32'h100, 4'b1111, 1'b1, 32'hDEADBEEF);
    push_res(1'b0, 1'b0, 32'h0);
    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 2, "sw_aligned");
  endtask

  task automatic test_split_load;
    mem[32'h100] = 32'h80112233;
    mem[32'h104] = 32'h44556677;
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
    push_beat(32'h104, 4'b0001, 1'b0, 32'h0);
    push_res(1'b1, 1'b0, 32'h00007780);
    run_op(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 5, "lh_split");
  endtask

  task automatic test_byte_loads;
    mem[32'h100] = 32'h0000F000;
    push_beat(32'h100, 4'b0010, 1'b0, 32'h0);
    push_res(1'b1, 1'b0, 32'h000000F0);
    run_op(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 0, 0, 3, "lbu");
    push_beat(32'h100, 4'b0010, 1'b0, 32'h0);
    push_res(1'b1, 1'b0, 32'hFFFFFFF0);
    run_op(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 0, 0, 3, "lb");
  endtask

  task automatic test_wrap_store;
    push_beat(32'hFFFFFFFC, 4'b1100, 1'b1, 32'h33440000);
    push_beat(32'h00000000, 4'b0011, 1'b1, 32'h00001122);
    push_res(1'b0, 1'b0, 32'h0);
    run_op(1'b0, 1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 0, 0, 3, "sw_wrap");
  endtask

  task automatic test_wait_states;
    mem[32'h200] = 32'h80011234;
    push_beat(32'h200, 4'b1100, 1'b0, 32'h0);
    push_res(1'b1, 1'b0, 32'hFFFF8001);
    run_op(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 3, 2, 8, "lh_wait");
  endtask

  task automatic test_back_to_back;
    mem[32'h300] = 32'h12345678;
    mem[32'h304] = 32'h99887766;
    push_beat(32'h300, 4'b0110, 1'b1, 32'h00ABCD00);
    push_res(1'b0, 1'b0, 32'h0);
    run_op(1'b0, 1'b1, 3'b001, 32'h301, 32'h0000ABCD, 0, 0, 2, "b2b_sh");
    push_beat(32'h300, 4'b1111, 1'b0, 32'h0);
    push_res(1'b1, 1'b0, 32'h12345678);
    run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 3, "b2b_lw");
    push_beat(32'h300, 4'b1000, 1'b1, 32'hAA000000);
    push_res(1'b0, 1'b0, 32'h0);
    run_op(1'b0, 1'b1, 3'b000, 32'h303, 32'h000000AA, 0, 0, 2, "b2b_sb");
    push_beat(32'h304, 4'b0110, 1'b0, 32'h0);
    push_res(1'b1, 1'b0, 32'h00008877);
    run_op(1'b1, 1'b0, 3'b101, 32'h305, 32'h0, 0, 0, 3, "b2b_lhu");
  endtask

  task automatic test_illegal;
    push_res(1'b0, 1'b1, 32'h0);
    run_op(1'b1, 1'b1, 3'b010, 32'h500, 32'h12345678, 0, 0, 1, "err_rw");
    push_res(1'b0, 1'b1, 32'h0);
    run_op(1'b1, 1'b0, 3'b011, 32'h500, 32'h0, 0, 0, 1, "err_load_f3");
    push_res(1'b0, 1'b1, 32'h0);
    run_op(1'b0, 1'b1, 3'b100, 32'h500, 32'h0, 0, 0, 1, "err_store_f3");
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    bus.memRead = 1; bus.func3 = 3'b010; bus.aluOut = 32'h400; bus.data2 = '0; bus.memGnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.memRead = 0;
      #1;
      checks++;
      if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h400 || bus.memBe !== 4'hF || bus.memWe !== 1'b0 || bus.stall !== 1'b1) begin
        errors++;
        $display("FAIL abort_hold: req=%b addr=%h be=%b we=%b stall=%b, required 1 400 1111 0 1",
                 bus.memReq, bus.memAddr, bus.memBe, bus.memWe, bus.stall);
      end
    end
    bus.memGnt = 1;
    @(negedge clk);
    bus.memGnt = 0;
    #1;
    checks++;
    if (bus.memReq !== 1'b0 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait1: req=%b stall=%b, required 0 1", bus.memReq, bus.stall);
    end
    rst = 1;
    #1;
    checks++;
    if (bus.memReq !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst: req=%b stall=%b, required 0 0", bus.memReq, bus.stall);
    end
    @(negedge clk);
    rst = 0; bus.memRvalid = 1; bus.memRdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.memRvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.loadValid !== 1'b0 || bus.stall !== 1'b0 || bus.memReq !== 1'b0 || bus.memData !== 32'h0) begin
        errors++;
        $display("FAIL abort_late_rvalid: lv=%b stall=%b req=%b data=%h, required 0 0 0 0",
                 bus.loadValid, bus.stall, bus.memReq, bus.memData);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_store();
    test_split_load();
    test_byte_loads();
    test_wrap_store();
    test_wait_states();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    checks++;
    if (beat_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: beats=%0d results=%0d left, required 0 0", beat_q.size(), res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
